// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the TCDM bank arbiter.
package tcdm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED  = 2'd0,
    ARB_RR     = 2'd1,
    ARB_STARVE = 2'd2,
    ARB_RSVD   = 2'd3
  } arb_policy_e;

  // Index width that stays at least one bit for a single initiator.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_arb_rr_sel.sv
// Rotating priority encoder: first set request at or after ptr, wrapping.
module tcdm_arb_rr_sel
  import tcdm_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic found;

  // Scan from ptr upward, take the first requester seen.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                      = 1'b1;
        idx                        = IW'((int'(ptr) + k) % N);
        onehot[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// N-to-1 arbiter in front of one TCDM bank with run-time selectable policy
// and a 1-cycle response return path to the granted initiator.
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int N_INIT    = 4,
  parameter int AW        = 13,
  parameter int DW        = 32,
  parameter int BW        = 8,
  parameter int MAX_STALL = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [1:0]               policy_i,
  input  logic [N_INIT-1:0]        req_i,
  input  logic [N_INIT*AW-1:0]     add_i,
  input  logic [N_INIT-1:0]        wen_i,
  input  logic [N_INIT*DW-1:0]     data_i,
  input  logic [N_INIT*DW/BW-1:0]  be_i,
  output logic [N_INIT-1:0]        gnt_o,
  output logic [N_INIT-1:0]        r_valid_o,
  output logic [DW-1:0]            r_data_o,
  output logic                     mem_req_o,
  output logic [AW-1:0]            mem_add_o,
  output logic                     mem_wen_o,
  output logic [DW-1:0]            mem_data_o,
  output logic [DW/BW-1:0]         mem_be_o,
  input  logic                     mem_gnt_i,
  input  logic [DW-1:0]            mem_rdata_i,
  output logic                     stall_max_o
);

  localparam int IW  = idx_w(N_INIT);
  localparam int CW  = $clog2(MAX_STALL + 1);
  localparam int BEW = DW / BW;
  localparam logic [CW-1:0] SAT = CW'(MAX_STALL);

  logic [IW-1:0]     rr_ptr;
  logic [CW-1:0]     stall_cnt [N_INIT];
  logic              resp_pend;
  logic [IW-1:0]     resp_idx;

  logic [N_INIT-1:0] sat_req;
  logic [N_INIT-1:0] fix_oh, rr_oh, sat_oh, win_oh;
  logic [IW-1:0]     fix_idx, rr_idx, sat_idx, win_idx;
  logic [IW-1:0]     rr_next;
  logic              req_any;
  logic              granted;

  tcdm_arb_rr_sel #(.N(N_INIT), .IW(IW)) u_sel_fix (
    .req(req_i), .ptr('0), .onehot(fix_oh), .idx(fix_idx)
  );

  tcdm_arb_rr_sel #(.N(N_INIT), .IW(IW)) u_sel_rr (
    .req(req_i), .ptr(rr_ptr), .onehot(rr_oh), .idx(rr_idx)
  );

  tcdm_arb_rr_sel #(.N(N_INIT), .IW(IW)) u_sel_sat (
    .req(sat_req), .ptr('0), .onehot(sat_oh), .idx(sat_idx)
  );

  // Starving requesters and the debug flag for any saturated counter.
  always_comb begin
    sat_req     = '0;
    stall_max_o = 1'b0;
    for (int i = 0; i < N_INIT; i++) begin
      sat_req[i]  = req_i[i] && (stall_cnt[i] == SAT);
      stall_max_o = stall_max_o | (stall_cnt[i] == SAT);
    end
  end

  // Policy mux: pick the winner, drive the bank and the grant.
  always_comb begin
    win_oh  = fix_oh;
    win_idx = fix_idx;
    case (arb_policy_e'(policy_i))
      ARB_FIXED: begin
        win_oh  = fix_oh;
        win_idx = fix_idx;
      end
      ARB_STARVE: begin
        if (|sat_req) begin
          win_oh  = sat_oh;
          win_idx = sat_idx;
        end
      end
      default: begin
        win_oh  = rr_oh;
        win_idx = rr_idx;
      end
    endcase

    req_any    = |req_i;
    mem_req_o  = req_any;
    mem_add_o  = '0;
    mem_wen_o  = 1'b0;
    mem_data_o = '0;
    mem_be_o   = '0;
    if (req_any) begin
      mem_add_o  = add_i[int'(win_idx)*AW +: AW];
      mem_wen_o  = wen_i[win_idx];
      mem_data_o = data_i[int'(win_idx)*DW +: DW];
      mem_be_o   = be_i[int'(win_idx)*BEW +: BEW];
    end

    granted = req_any && mem_gnt_i;
    gnt_o   = granted ? win_oh : '0;
    rr_next = (int'(win_idx) == N_INIT - 1) ? '0 : IW'(int'(win_idx) + 1);
  end

  // Response return: valid one cycle after a grant, data only while valid.
  always_comb begin
    r_valid_o = '0;
    r_data_o  = '0;
    if (resp_pend) begin
      r_valid_o[resp_idx] = 1'b1;
      r_data_o            = mem_rdata_i;
    end
  end

  // Round-robin pointer follows every grant; clear wins over the update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rr_ptr <= '0;
    else if (clear_i) rr_ptr <= '0;
    else if (granted) rr_ptr <= rr_next;
  end

  // Per-initiator wait counters, saturating at MAX_STALL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_INIT; i++) stall_cnt[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < N_INIT; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_INIT; i++) begin
        if (!req_i[i] || gnt_o[i])  stall_cnt[i] <= '0;
        else if (stall_cnt[i] != SAT) stall_cnt[i] <= stall_cnt[i] + CW'(1);
      end
    end
  end

  // Response tracking register; a grant in a clear cycle is still honoured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_pend <= 1'b0;
      resp_idx  <= '0;
    end else begin
      resp_pend <= granted;
      if (granted) resp_idx <= win_idx;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter (N_INIT=4, MAX_STALL=3).
module tb_tcdm_bank_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int MS = 3;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              clear;
  logic [1:0]        policy;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   add;
  logic [N-1:0]      wen;
  logic [N*DW-1:0]   data;
  logic [N*DW/BW-1:0] be;
  logic [N-1:0]      gnt;
  logic [N-1:0]      r_valid;
  logic [DW-1:0]     r_data;
  logic              mem_req;
  logic [AW-1:0]     mem_add;
  logic              mem_wen;
  logic [DW-1:0]     mem_data;
  logic [DW/BW-1:0]  mem_be;
  logic              mem_gnt;
  logic [DW-1:0]     mem_rdata;
  logic              stall_max;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tcdm_bank_arbiter #(
    .N_INIT(N), .AW(AW), .DW(DW), .BW(BW), .MAX_STALL(MS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .policy_i(policy),
    .req_i(req), .add_i(add), .wen_i(wen), .data_i(data), .be_i(be),
    .gnt_o(gnt), .r_valid_o(r_valid), .r_data_o(r_data),
    .mem_req_o(mem_req), .mem_add_o(mem_add), .mem_wen_o(mem_wen),
    .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_gnt_i(mem_gnt),
    .mem_rdata_i(mem_rdata), .stall_max_o(stall_max)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; clear = 1'b0; policy = 2'd0; req = '0; add = '0;
    wen = '1; data = '0; be = '0; mem_gnt = 1'b1; mem_rdata = '0;
    #1;
    chk("rst_rvalid", 32'(r_valid), 32'h0);
    chk("rst_rdata", r_data, 32'h0);
    chk("rst_memreq", 32'(mem_req), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_stallmax", 32'(stall_max), 32'h0);
    @(negedge clk); rst_ni = 1'b1;

    // Fixed priority, all requesting.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); policy = 2'd0; req = 4'b1111; #1;
      chk("p0_gnt", 32'(gnt), 32'h1);
      chk("p0_rvalid", 32'(r_valid), (c == 0) ? 32'h0 : 32'h1);
    end
    @(negedge clk); req = '0; clear = 1'b1; #1;
    chk("p0_last_rvalid", 32'(r_valid), 32'h1);
    chk("clr_gnt", 32'(gnt), 32'h0);

    // Round-robin sweep with wrap.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); clear = 1'b0; policy = 2'd1; req = 4'b1111; #1;
      chk("p1_gnt", 32'(gnt), 32'(1 << (c % 4)));
    end
    @(negedge clk); req = '0; clear = 1'b1; #1;
    chk("p1_last_rvalid", 32'(r_valid), 32'h1);

    // Starvation-bounded: initiator 1 promoted after 3 waits.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); clear = 1'b0; policy = 2'd2; req = 4'b0011; #1;
      chk("p2_gnt", 32'(gnt), (c < 3) ? 32'h1 : 32'h2);
    end
    chk("p2_stallmax_set", 32'(stall_max), 32'h1);
    @(negedge clk); #1;
    chk("p2_gnt_after", 32'(gnt), 32'h1);
    chk("p2_stallmax_clr", 32'(stall_max), 32'h0);
    chk("p2_rvalid", 32'(r_valid), 32'h2);

    // Read from initiator 2.
    @(negedge clk); policy = 2'd0; req = 4'b0100; add[2*AW +: AW] = 13'h12; wen = '1; #1;
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_add", 32'(mem_add), 32'h12);
    chk("rd_wen", 32'(mem_wen), 32'h1);
    @(negedge clk); req = '0; add = '0; mem_rdata = 32'hDEADBEEF; #1;
    chk("rd_rvalid", 32'(r_valid), 32'h4);
    chk("rd_rdata", r_data, 32'hDEADBEEF);
    chk("idle_memreq", 32'(mem_req), 32'h0);
    chk("idle_add", 32'(mem_add), 32'h0);

    // Write from initiator 3.
    @(negedge clk); req = 4'b1000; wen = 4'b0111; data[3*DW +: DW] = 32'hCAFEF00D;
    be[3*4 +: 4] = 4'b0101; mem_rdata = '0; #1;
    chk("wr_gnt", 32'(gnt), 32'h8);
    chk("wr_wen", 32'(mem_wen), 32'h0);
    chk("wr_data", mem_data, 32'hCAFEF00D);
    chk("wr_be", 32'(mem_be), 32'h5);
    @(negedge clk); req = '0; wen = '1; data = '0; be = '0; #1;
    chk("wr_rvalid", 32'(r_valid), 32'h8);
    chk("wr_rdata", r_data, 32'h0);
    @(negedge clk); mem_rdata = 32'h55; #1;
    chk("nores_rvalid", 32'(r_valid), 32'h0);
    chk("nores_rdata", r_data, 32'h0);

    // Bank stall: counter saturates, no grant, no response.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); policy = 2'd2; req = 4'b0010; mem_gnt = 1'b0; #1;
      chk("stall_gnt", 32'(gnt), 32'h0);
      chk("stall_memreq", 32'(mem_req), 32'h1);
      chk("stall_rvalid", 32'(r_valid), 32'h0);
      chk("stall_max", 32'(stall_max), (c >= MS) ? 32'h1 : 32'h0);
    end
    @(negedge clk); mem_gnt = 1'b1; #1;
    chk("stall_release_gnt", 32'(gnt), 32'h2);
    @(negedge clk); req = '0; #1;
    chk("stall_release_rvalid", 32'(r_valid), 32'h2);
    chk("stall_release_max", 32'(stall_max), 32'h0);

    // Async reset right after a grant.
    @(negedge clk); policy = 2'd1; req = 4'b0001; #1;
    chk("rst_pre_gnt", 32'(gnt), 32'h1);
    @(negedge clk); req = '0; mem_rdata = 32'hAA; #1;
    chk("rst_pre_rvalid", 32'(r_valid), 32'h1);
    chk("rst_pre_rdata", r_data, 32'hAA);
    rst_ni = 1'b0; #1;
    chk("rst_async_rvalid", 32'(r_valid), 32'h0);
    chk("rst_async_rdata", r_data, 32'h0);
    chk("rst_async_memreq", 32'(mem_req), 32'h0);
    @(negedge clk); rst_ni = 1'b1; req = 4'b1111; #1;
    chk("rst_rrptr_gnt", 32'(gnt), 32'h1);

    // Clear in the same cycle as a grant.
    @(negedge clk); req = 4'b0100; clear = 1'b1; #1;
    chk("clr_same_gnt", 32'(gnt), 32'h4);
    @(negedge clk); clear = 1'b0; req = 4'b1111; #1;
    chk("clr_resp_rvalid", 32'(r_valid), 32'h4);
    chk("clr_rrptr_gnt", 32'(gnt), 32'h1);
    @(negedge clk); policy = 2'd3; #1;
    chk("p3_gnt", 32'(gnt), 32'h2);

    @(negedge clk); req = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
